// File: rtl/be_rr_scheduler.sv
// be_rr_scheduler: round-robin arbiter that shares one packet backend engine
// between NUM_REQ frontend buffers. It holds one job per frontend, dispatches
// jobs one at a time, drives the BRAM read mux select and returns a per-frontend
// finish pulse.
// Optional build macro: BE_TIMEOUT_EN (adds a WAIT_FIN watchdog and the
// sticky timeout_err output).
module be_rr_scheduler #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned LEN_W       = 16,
  parameter int unsigned MAX_LEN     = 1514,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [NUM_REQ-1:0]         req_start,
  input  logic [NUM_REQ*LEN_W-1:0]   req_length,
  output logic [NUM_REQ-1:0]         req_finish,
  output logic                       be_start,
  output logic [LEN_W-1:0]           be_length,
  input  logic                       be_finish,
  output logic [$clog2(NUM_REQ)-1:0] be_sel,
  output logic                       busy,
  output logic [NUM_REQ-1:0]         overrun,
  output logic [7:0]                 len_err_cnt
`ifdef BE_TIMEOUT_EN
  ,
  output logic                       timeout_err
`endif
);

  localparam int unsigned SEL_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_FIN,
    S_RELEASE
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_pending;
  logic [LEN_W-1:0]   r_len [NUM_REQ];
  logic [SEL_W-1:0]   r_ptr, w_ptr_nxt;
  logic [SEL_W-1:0]   r_sel, w_sel_nxt;
  logic [LEN_W-1:0]   r_be_len, w_be_len_nxt;
  logic               r_be_start, w_be_start_nxt;
  logic               r_busy, w_busy_nxt;
  logic [NUM_REQ-1:0] r_req_fin, w_req_fin_nxt;
  logic [NUM_REQ-1:0] r_overrun;
  logic [7:0]         r_err_cnt, w_err_cnt_nxt;

  logic [NUM_REQ-1:0] w_clr;
  logic [NUM_REQ-1:0] w_accept;
  logic               w_any;
  logic [SEL_W-1:0]   w_win;
  int unsigned        w_idx;
  logic [LEN_W-1:0]   w_win_len;
  logic               w_bad;
  logic               w_tmo_hit;

  function automatic logic [SEL_W-1:0] f_inc(input logic [SEL_W-1:0] v);
    return (32'(v) == NUM_REQ - 1) ? '0 : v + 1'b1;
  endfunction

`ifdef BE_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC) + 1;
  logic [WD_W-1:0] r_wd;
  logic            r_tmo_err;

  assign w_tmo_hit = (r_state == S_WAIT_FIN) && (r_wd == WD_W'(TIMEOUT_CYC - 1));

  // Watchdog: idles at zero outside WAIT_FIN so it starts from zero on entry
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wd      <= '0;
      r_tmo_err <= 1'b0;
    end else begin
      if (r_state != S_WAIT_FIN) r_wd <= '0;
      else                       r_wd <= r_wd + 1'b1;
      if (w_tmo_hit && !be_finish) r_tmo_err <= 1'b1;
    end
  end

  assign timeout_err = r_tmo_err;
`else
  assign w_tmo_hit = 1'b0;
`endif

  // Round-robin winner: first pending bit searching upward from r_ptr
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = (32'(r_ptr) + k) % NUM_REQ;
      if (!w_any && r_pending[SEL_W'(w_idx)]) begin
        w_any = 1'b1;
        w_win = SEL_W'(w_idx);
      end
    end
  end

  assign w_win_len = r_len[w_win];
  assign w_bad     = (w_win_len == '0) || (w_win_len > LEN_W'(MAX_LEN));

  // Next-state and next-output logic for the dispatch FSM
  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_sel_nxt      = r_sel;
    w_be_len_nxt   = r_be_len;
    w_be_start_nxt = 1'b0;
    w_busy_nxt     = r_busy;
    w_req_fin_nxt  = '0;
    w_err_cnt_nxt  = r_err_cnt;
    w_clr          = '0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          if (w_bad) begin
            w_req_fin_nxt[w_win] = 1'b1;
            w_clr[w_win]         = 1'b1;
            w_ptr_nxt            = f_inc(w_win);
            if (r_err_cnt != 8'hFF) w_err_cnt_nxt = r_err_cnt + 8'd1;
          end else begin
            w_sel_nxt      = w_win;
            w_be_len_nxt   = w_win_len;
            w_be_start_nxt = 1'b1;
            w_busy_nxt     = 1'b1;
            w_state_nxt    = S_WAIT_FIN;
          end
        end
      end
      S_WAIT_FIN: begin
        if (be_finish || w_tmo_hit) begin
          w_req_fin_nxt[r_sel] = 1'b1;
          w_clr[r_sel]         = 1'b1;
          w_ptr_nxt            = f_inc(r_sel);
          w_busy_nxt           = 1'b0;
          w_state_nxt          = S_RELEASE;
        end
      end
      S_RELEASE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM and dispatch output registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_sel      <= '0;
      r_be_len   <= '0;
      r_be_start <= 1'b0;
      r_busy     <= 1'b0;
      r_req_fin  <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_sel      <= w_sel_nxt;
      r_be_len   <= w_be_len_nxt;
      r_be_start <= w_be_start_nxt;
      r_busy     <= w_busy_nxt;
      r_req_fin  <= w_req_fin_nxt;
      r_err_cnt  <= w_err_cnt_nxt;
    end
  end

  // A new post is accepted into a free slot, or into a slot being released on
  // this same edge (set beats clear); a post into an occupied slot is an overrun.
  assign w_accept = req_start & (~r_pending | w_clr);

  // Per-requester job slots and sticky overrun flags
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_pending <= '0;
      r_overrun <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) r_len[i] <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_accept;
      r_overrun <= r_overrun | (req_start & r_pending & ~w_clr);
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (w_accept[i]) r_len[i] <= req_length[i*LEN_W +: LEN_W];
      end
    end
  end

  assign req_finish  = r_req_fin;
  assign be_start    = r_be_start;
  assign be_length   = r_be_len;
  assign be_sel      = r_sel;
  assign busy        = r_busy;
  assign overrun     = r_overrun;
  assign len_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_be_rr_scheduler.sv
// Directed bench for be_rr_scheduler with a dispatch/finish scoreboard.
module tb_be_rr_scheduler;

  localparam int NR = 4;
  localparam int LW = 16;

  logic           aclk = 1'b0;
  logic           aresetn = 1'b0;
  logic [NR-1:0]  req_start = '0;
  logic [NR*LW-1:0] req_length = '0;
  logic [NR-1:0]  req_finish;
  logic           be_start;
  logic [LW-1:0]  be_length;
  logic           be_finish = 1'b0;
  logic [1:0]     be_sel;
  logic           busy;
  logic [NR-1:0]  overrun;
  logic [7:0]     len_err_cnt;
`ifdef BE_TIMEOUT_EN
  logic           timeout_err;
`endif

  int total = 0;
  int bad   = 0;

  int be_sel_q[$];
  int be_len_q[$];
  int fin_q[$];

  always #5 aclk = ~aclk;

  be_rr_scheduler #(
    .NUM_REQ(NR), .LEN_W(LW), .MAX_LEN(1514), .TIMEOUT_CYC(16)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_start(req_start), .req_length(req_length), .req_finish(req_finish),
    .be_start(be_start), .be_length(be_length), .be_finish(be_finish),
    .be_sel(be_sel), .busy(busy), .overrun(overrun), .len_err_cnt(len_err_cnt)
`ifdef BE_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic post(input int i, input int len);
    req_start[i] = 1'b1;
    req_length[i*LW +: LW] = LW'(len);
    step();
    req_start = '0;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!be_start && n < 40) begin
      step();
      n++;
    end
    chk(tag, be_start, 1);
  endtask

  task automatic fin_after(input int n);
    repeat (n) step();
    be_finish = 1'b1;
    step();
    be_finish = 1'b0;
  endtask

  // Scoreboard: every dispatch and finish pulse is matched against the queues
  always @(negedge aclk) begin
    if (aresetn) begin
      if (be_start) begin
        if (be_sel_q.size() == 0) begin
          chk("unexpected_be_start", 1, 0);
        end else begin
          chk("sb_be_sel", be_sel, be_sel_q.pop_front());
          chk("sb_be_length", be_length, be_len_q.pop_front());
        end
      end
      if (req_finish != '0) begin
        if (fin_q.size() == 0) chk("unexpected_req_finish", req_finish, 0);
        else chk("sb_req_finish", req_finish, 32'(1) << fin_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int gap;
    // Reset state
    step();
    chk("rst_req_finish", req_finish, 0);
    chk("rst_be_start", be_start, 0);
    chk("rst_be_length", be_length, 0);
    chk("rst_be_sel", be_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_len_err_cnt", len_err_cnt, 0);
    aresetn = 1'b1;
    step();

    // Fairness: all four post together, pointer starts at 0
    for (int i = 0; i < NR; i++) begin
      req_length[i*LW +: LW] = 16'd60;
      be_sel_q.push_back(i); be_len_q.push_back(60); fin_q.push_back(i);
    end
    req_start = 4'b1111;
    step();
    req_start = '0;
    for (int k = 0; k < NR; k++) begin
      wait_start("fair_start");
      chk("fair_sel", be_sel, k);
      repeat (5) step();
      be_finish = 1'b1;
      step();
      be_finish = 1'b0;
      gap = 1;
      if (k < NR - 1) begin
        while (!be_start && gap < 20) begin
          step();
          gap++;
        end
        chk("fair_gap", gap, 3);
      end
    end
    step(); step();

    // Single job: exact latencies
    be_sel_q.push_back(0); be_len_q.push_back(1514); fin_q.push_back(0);
    post(0, 1514);                       // now cycle 1
    chk("single_no_early_start", be_start, 0);
    step();                              // cycle 2
    chk("single_be_start", be_start, 1);
    chk("single_busy", busy, 1);
    repeat (3) step();                   // cycle 5
    chk("single_be_start_width", be_start, 0);
    chk("single_len_held", be_length, 1514);
    repeat (5) step();                   // cycle 10
    be_finish = 1'b1;
    step();                              // cycle 11
    be_finish = 1'b0;
    chk("single_req_finish", req_finish, 4'b0001);
    chk("single_busy_clr", busy, 0);
    step();
    chk("single_release", req_finish, 0);
    step();

    // Stray be_finish in IDLE is ignored
    be_finish = 1'b1;
    step();
    be_finish = 1'b0;
    chk("stray_finish_ignored", req_finish, 0);
    chk("stray_finish_busy", busy, 0);

    // Round robin: after serving 1, requester 3 beats 0
    be_sel_q.push_back(1); be_len_q.push_back(64); fin_q.push_back(1);
    post(1, 64);
    wait_start("rr_start1");
    fin_after(2);
    step(); step();
    be_sel_q.push_back(3); be_len_q.push_back(80); fin_q.push_back(3);
    be_sel_q.push_back(0); be_len_q.push_back(70); fin_q.push_back(0);
    req_length[0*LW +: LW] = 16'd70;
    req_length[3*LW +: LW] = 16'd80;
    req_start = 4'b1001;
    step();
    req_start = '0;
    wait_start("rr_start3");
    chk("rr_first_is_3", be_sel, 3);
    fin_after(2);
    wait_start("rr_start0");
    chk("rr_second_is_0", be_sel, 0);
    fin_after(2);
    step(); step();

    // Length reject: zero and oversize
    fin_q.push_back(2);
    post(2, 0);
    step();
    chk("rej0_finish", req_finish, 4'b0100);
    fin_q.push_back(2);
    post(2, 1600);
    step();
    chk("rej1600_finish", req_finish, 4'b0100);
    repeat (3) step();
    chk("rej_len_err_cnt", len_err_cnt, 2);
    chk("rej_busy", busy, 0);

    // Overrun, then reset in WAIT_FIN
    be_sel_q.push_back(1); be_len_q.push_back(100);
    post(1, 100);
    post(1, 200);
    chk("ovr_flag", overrun, 4'b0010);
    chk("ovr_be_start", be_start, 1);
    chk("ovr_be_length", be_length, 100);
    step();
    aresetn = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_be_start", be_start, 0);
    chk("arst_overrun", overrun, 0);
    step(); step();
    aresetn = 1'b1;
    repeat (4) step();
    chk("post_rst_idle_busy", busy, 0);
    chk("post_rst_err_cnt", len_err_cnt, 0);

`ifdef BE_TIMEOUT_EN
    // Watchdog completes a job the backend never finishes
    be_sel_q.push_back(0); be_len_q.push_back(50); fin_q.push_back(0);
    post(0, 50);
    wait_start("tmo_start");
    repeat (15) step();
    chk("tmo_not_yet", req_finish, 0);
    step();
    chk("tmo_req_finish", req_finish, 4'b0001);
    chk("tmo_err", timeout_err, 1);
    step(); step();
`endif

    chk("sb_be_queue_empty", be_sel_q.size(), 0);
    chk("sb_fin_queue_empty", fin_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
